// File: rtl/load_pkg.sv
// Shared types and helpers for the load path: load type and cause encodings,
// FSM state names and lane-size helpers.
package load_pkg;

  typedef enum logic [2:0] {
    LT_LB  = 3'd0,
    LT_LH  = 3'd1,
    LT_LW  = 3'd2,
    LT_LD  = 3'd3,
    LT_LBU = 3'd4,
    LT_LHU = 3'd5,
    LT_LWU = 3'd6,
    LT_ILL = 3'd7
  } load_type_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MISALIGN = 2'd1,
    CAUSE_ACCESS   = 2'd2,
    CAUSE_ILLEGAL  = 2'd3
  } cause_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam int XLEN_DEFAULT = 32;

  // Byte-offset width inside one XLEN word.
  function automatic int off_w(input int xlen);
    return $clog2(xlen / 8);
  endfunction

  // Offset width for the default XLEN; parametrised users call off_w().
  localparam int OFF_W = off_w(XLEN_DEFAULT);

  // Lane size in bytes; the illegal encoding reports 1 so callers never
  // build a zero-width mask from it.
  function automatic int type_bytes(input load_type_e t);
    case (t)
      LT_LB, LT_LBU: return 1;
      LT_LH, LT_LHU: return 2;
      LT_LW, LT_LWU: return 4;
      LT_LD:         return 8;
      default:       return 1;
    endcase
  endfunction

  function automatic logic type_signed(input load_type_e t);
    return (t == LT_LB) || (t == LT_LH) || (t == LT_LW) || (t == LT_LD);
  endfunction

  // LD and LWU only exist on a 64-bit datapath.
  function automatic logic type_legal(input load_type_e t, input int xlen);
    case (t)
      LT_LD, LT_LWU: return (xlen == 64);
      LT_ILL:        return 1'b0;
      default:       return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_unit_if.sv
// Data-memory read port between the load unit (master) and memory (slave).
interface load_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_rerr;

  modport master (
    output mem_req_valid, mem_addr,
    input  mem_req_ready, mem_rvalid, mem_rdata, mem_rerr
  );

  modport slave (
    input  mem_req_valid, mem_addr,
    output mem_req_ready, mem_rvalid, mem_rdata, mem_rerr
  );
endinterface

// File: rtl/load_extend.sv
// Lane extraction and sign/zero extension of an aligned memory word.
module load_extend
  import load_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int OFF_BITS = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]     data,
  input  logic [OFF_BITS-1:0] offset,
  input  load_type_e          ltype,
  output logic [XLEN-1:0]     result
);

  localparam logic [XLEN-1:0] ONE = XLEN'(1);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mask;
  logic [XLEN-1:0] sign_pos;
  logic            sign_bit;
  int              lane_bits;

  // Shift the addressed lane to bit 0, then fill above it with sign or zero.
  always_comb begin
    shifted   = data >> {offset, 3'b000};
    lane_bits = 8 * type_bytes(ltype);
    if (lane_bits >= XLEN) begin
      mask     = '1;
      sign_pos = ONE << (XLEN - 1);
    end else begin
      mask     = (ONE << lane_bits) - ONE;
      sign_pos = ONE << (lane_bits - 1);
    end
    sign_bit = type_signed(ltype) && ((shifted & sign_pos) != '0);
    result   = sign_bit ? (shifted | ~mask) : (shifted & mask);
  end

endmodule

// File: rtl/load_unit.sv
// Sequential load path: check, aligned memory read, lane extend, respond.
//
// state | meaning
// IDLE  | ready for a request; illegal/misaligned requests go straight to RESP
// REQ   | memory read request outstanding (mem_req_valid high)
// WAIT  | request accepted by memory, waiting for mem_rvalid
// RESP  | result registered, rsp_valid high until rsp_ready or flush
//
// A flush during REQ/WAIT cannot abort the memory transaction, so the load
// is marked killed and its response is swallowed on arrival.
module load_unit
  import load_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_type,
  load_unit_if.master       mem,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic              rsp_fault,
  output logic [1:0]        rsp_cause
);

  localparam int OFF_BITS = off_w(XLEN);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  load_type_e        type_q;
  logic              killed_q, killed_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic              fault_q, fault_d;
  cause_e            cause_q, cause_d;

  load_type_e        req_type_e;
  logic              accept;
  logic              req_illegal;
  logic              req_misalign;
  logic [XLEN-1:0]   ext_data;

  assign req_type_e   = load_type_e'(req_type);
  assign accept       = (state_q == ST_IDLE) && req_valid && !flush;
  assign req_illegal  = !type_legal(req_type_e, XLEN);
  assign req_misalign = (req_addr[2:0] & 3'(type_bytes(req_type_e) - 1)) != 3'b000;

  load_extend #(
    .XLEN     (XLEN),
    .OFF_BITS (OFF_BITS)
  ) u_extend (
    .data   (mem.mem_rdata),
    .offset (addr_q[OFF_BITS-1:0]),
    .ltype  (type_q),
    .result (ext_data)
  );

  // State and result registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      type_q   <= LT_LB;
      killed_q <= 1'b0;
      data_q   <= '0;
      fault_q  <= 1'b0;
      cause_q  <= CAUSE_NONE;
    end else begin
      state_q  <= state_d;
      killed_q <= killed_d;
      data_q   <= data_d;
      fault_q  <= fault_d;
      cause_q  <= cause_d;
      if (accept) begin
        addr_q <= req_addr;
        type_q <= req_type_e;
      end
    end
  end

  // Next state, kill tracking and result capture.
  always_comb begin
    state_d  = state_q;
    killed_d = killed_q;
    data_d   = data_q;
    fault_d  = fault_q;
    cause_d  = cause_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_illegal) begin
            state_d = ST_RESP;
            data_d  = '0;
            fault_d = 1'b1;
            cause_d = CAUSE_ILLEGAL;
          end else if (req_misalign) begin
            state_d = ST_RESP;
            data_d  = '0;
            fault_d = 1'b1;
            cause_d = CAUSE_MISALIGN;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (flush) killed_d = 1'b1;
        if (mem.mem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (flush) killed_d = 1'b1;
        if (mem.mem_rvalid) begin
          if (killed_q || flush) begin
            state_d  = ST_IDLE;
            killed_d = 1'b0;
          end else begin
            state_d = ST_RESP;
            if (mem.mem_rerr) begin
              data_d  = '0;
              fault_d = 1'b1;
              cause_d = CAUSE_ACCESS;
            end else begin
              data_d  = ext_data;
              fault_d = 1'b0;
              cause_d = CAUSE_NONE;
            end
          end
        end
      end
      ST_RESP: begin
        if (flush || rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    req_ready         = (state_q == ST_IDLE) && !flush;
    mem.mem_req_valid = (state_q == ST_REQ);
    mem.mem_addr      = {addr_q[ADDR_W-1:OFF_BITS], {OFF_BITS{1'b0}}};
    rsp_valid         = (state_q == ST_RESP);
    rsp_data          = data_q;
    rsp_fault         = fault_q;
    rsp_cause         = cause_q;
  end

endmodule

// File: tb/tb_load_unit.sv
// Testbench for load_unit: a 32-bit and a 64-bit instance, exercised one
// at a time through a shared set of stimulus signals.
module tb_load_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, req_valid, rsp_ready, sel64;
  logic [31:0] req_addr;
  logic [2:0]  req_type;
  logic        mem_req_ready, mem_rvalid, mem_rerr;
  logic [63:0] mem_rdata;

  logic        r32_req_ready, r32_rsp_valid, r32_rsp_fault;
  logic [31:0] r32_rsp_data;
  logic [1:0]  r32_rsp_cause;
  logic        r64_req_ready, r64_rsp_valid, r64_rsp_fault;
  logic [63:0] r64_rsp_data;
  logic [1:0]  r64_rsp_cause;

  load_unit_if #(.XLEN(32), .ADDR_W(32)) mif32 ();
  load_unit_if #(.XLEN(64), .ADDR_W(32)) mif64 ();

  assign mif32.mem_req_ready = mem_req_ready & ~sel64;
  assign mif32.mem_rvalid    = mem_rvalid & ~sel64;
  assign mif32.mem_rdata     = mem_rdata[31:0];
  assign mif32.mem_rerr      = mem_rerr;
  assign mif64.mem_req_ready = mem_req_ready & sel64;
  assign mif64.mem_rvalid    = mem_rvalid & sel64;
  assign mif64.mem_rdata     = mem_rdata;
  assign mif64.mem_rerr      = mem_rerr;

  load_unit #(.XLEN(32), .ADDR_W(32)) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush & ~sel64),
    .req_valid (req_valid & ~sel64),
    .req_ready (r32_req_ready),
    .req_addr  (req_addr),
    .req_type  (req_type),
    .mem       (mif32),
    .rsp_valid (r32_rsp_valid),
    .rsp_ready (rsp_ready & ~sel64),
    .rsp_data  (r32_rsp_data),
    .rsp_fault (r32_rsp_fault),
    .rsp_cause (r32_rsp_cause)
  );

  load_unit #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush & sel64),
    .req_valid (req_valid & sel64),
    .req_ready (r64_req_ready),
    .req_addr  (req_addr),
    .req_type  (req_type),
    .mem       (mif64),
    .rsp_valid (r64_rsp_valid),
    .rsp_ready (rsp_ready & sel64),
    .rsp_data  (r64_rsp_data),
    .rsp_fault (r64_rsp_fault),
    .rsp_cause (r64_rsp_cause)
  );

  logic        o_req_ready, o_mem_req_valid, o_rsp_valid, o_rsp_fault;
  logic [31:0] o_mem_addr;
  logic [63:0] o_rsp_data;
  logic [1:0]  o_rsp_cause;

  assign o_req_ready     = sel64 ? r64_req_ready : r32_req_ready;
  assign o_mem_req_valid = sel64 ? mif64.mem_req_valid : mif32.mem_req_valid;
  assign o_mem_addr      = sel64 ? mif64.mem_addr : mif32.mem_addr;
  assign o_rsp_valid     = sel64 ? r64_rsp_valid : r32_rsp_valid;
  assign o_rsp_fault     = sel64 ? r64_rsp_fault : r32_rsp_fault;
  assign o_rsp_data      = sel64 ? r64_rsp_data : {32'h0, r32_rsp_data};
  assign o_rsp_cause     = sel64 ? r64_rsp_cause : r32_rsp_cause;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: what a load of type t at addr should return from rdata.
  function automatic void model(input bit x64, input logic [31:0] addr, input logic [2:0] t,
                                input logic [63:0] rdata, input bit rerr,
                                output logic [1:0] cause, output logic [63:0] data,
                                output bit use_mem);
    int nb, xl, off;
    bit sgn;
    logic [63:0] v, lane_mask, xmask;
    xl = x64 ? 64 : 32;
    xmask = x64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    sgn = (t <= 3'd3);
    case (t)
      3'd0, 3'd4: nb = 1;
      3'd1, 3'd5: nb = 2;
      3'd2, 3'd6: nb = 4;
      3'd3:       nb = 8;
      default:    nb = 0;
    endcase
    use_mem = 1'b0;
    data = 64'h0;
    if (nb == 0 || (nb * 8 > xl) || (t == 3'd6 && !x64)) begin
      cause = 2'd3;
    end else if ((addr % nb) != 0) begin
      cause = 2'd1;
    end else begin
      use_mem = 1'b1;
      if (rerr) begin
        cause = 2'd2;
      end else begin
        cause = 2'd0;
        off = int'(addr % (xl / 8));
        v = (rdata & xmask) >> (8 * off);
        lane_mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        v = v & lane_mask;
        if (sgn && v[8 * nb - 1]) v = v | ~lane_mask;
        data = v & xmask;
      end
    end
  endfunction

  task automatic idle_inputs();
    flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_addr = '0; req_type = '0;
    mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rerr = 1'b0; mem_rdata = '0;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_req_ready"}, o_req_ready, 1);
    check_val({tag, "_mem_req_valid"}, o_mem_req_valid, 0);
    check_val({tag, "_rsp_valid"}, o_rsp_valid, 0);
  endtask

  // fmode: 0 none, 1 flush in REQ, 2 flush in WAIT, 3 flush in RESP,
  // 4 flush together with rsp_ready.
  task automatic run_load(input bit x64, input logic [31:0] addr, input logic [2:0] typ,
                          input logic [63:0] rdata, input bit rerr,
                          input int mem_stall, input int rsp_stall, input int fmode);
    logic [1:0]  ecause;
    logic [63:0] edata;
    logic [31:0] eaddr;
    bit          use_mem, killed;
    int          last;
    model(x64, addr, typ, rdata, rerr, ecause, edata, use_mem);
    eaddr  = addr & ~(x64 ? 32'd7 : 32'd3);
    killed = use_mem && (fmode == 1 || fmode == 2);
    last   = (fmode == 3) ? 0 : rsp_stall;

    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_type = typ;
    #1 check_val("req_ready_accept", o_req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_type = 3'($urandom);
    if (use_mem) begin
      for (int i = 0; i <= mem_stall; i++) begin
        if (i > 0) @(negedge clk);
        mem_req_ready = (i == mem_stall);
        flush = (fmode == 1 && i == 0);
        #1;
        check_val("mem_req_valid", o_mem_req_valid, 1);
        check_val("mem_addr", o_mem_addr, eaddr);
        check_val("rsp_valid_in_req", o_rsp_valid, 0);
        check_val("req_ready_busy", o_req_ready, 0);
      end
      @(negedge clk);
      mem_req_ready = 1'b0; flush = (fmode == 2);
      mem_rvalid = 1'b1; mem_rdata = rdata; mem_rerr = rerr;
      #1;
      check_val("mem_req_valid_wait", o_mem_req_valid, 0);
      check_val("rsp_valid_in_wait", o_rsp_valid, 0);
      @(negedge clk);
      flush = 1'b0; mem_rvalid = 1'b0; mem_rerr = 1'b0; mem_rdata = {$urandom, $urandom};
      if (killed) begin
        #1;
        check_val("rsp_valid_killed", o_rsp_valid, 0);
        check_val("req_ready_after_kill", o_req_ready, 1);
        return;
      end
    end else begin
      #1 check_val("mem_req_valid_rejected", o_mem_req_valid, 0);
    end
    for (int i = 0; i <= last; i++) begin
      if (i > 0) @(negedge clk);
      rsp_ready = (fmode != 3) && (i == last);
      flush = (fmode == 3) || (fmode == 4 && i == last);
      #1;
      check_val("rsp_valid", o_rsp_valid, 1);
      check_val("rsp_data", o_rsp_data, edata);
      check_val("rsp_fault", o_rsp_fault, (ecause != 2'd0));
      check_val("rsp_cause", o_rsp_cause, ecause);
      check_val("req_ready_in_resp", o_req_ready, 0);
    end
    @(negedge clk);
    rsp_ready = 1'b0; flush = 1'b0;
    #1 check_idle("after_resp");
  endtask

  task automatic flush_in_idle();
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h40; req_type = 3'd2;
    #1 check_val("req_ready_flush_idle", o_req_ready, 0);
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    #1 check_idle("flush_idle");
  endtask

  task automatic reset_mid_load();
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h100; req_type = 3'd2;
    @(negedge clk);
    req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_idle("mid_reset");
    check_val("mid_reset_rsp_data", o_rsp_data, 0);
  endtask

  task automatic random_loads(input bit x64, input int n);
    logic [31:0] a;
    int fm;
    for (int k = 0; k < n; k++) begin
      a  = {20'h0, 12'($urandom)};
      fm = $urandom_range(0, 12);
      if (fm > 4) fm = 0;
      run_load(x64, a, 3'($urandom), {$urandom, $urandom}, ($urandom_range(0, 7) == 0),
               $urandom_range(0, 3), $urandom_range(0, 3), fm);
    end
  endtask

  initial begin
    idle_inputs();
    sel64 = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_idle("reset32");
    check_val("reset32_rsp_data", o_rsp_data, 0);
    check_val("reset32_rsp_fault", o_rsp_fault, 0);
    check_val("reset32_rsp_cause", o_rsp_cause, 0);
    sel64 = 1'b1;
    #1;
    check_idle("reset64");
    check_val("reset64_rsp_data", o_rsp_data, 0);
    sel64 = 1'b0;

    run_load(0, 32'h1003, 3'd0, 64'h80123456, 0, 0, 0, 0);
    run_load(0, 32'h1002, 3'd5, 64'hBEEF1234, 0, 0, 0, 0);
    run_load(0, 32'h1000, 3'd1, 64'hBEEF1234, 0, 0, 0, 0);
    run_load(0, 32'h1001, 3'd2, 64'h11223344, 0, 0, 0, 0);
    run_load(0, 32'h1000, 3'd3, 64'h11223344, 0, 0, 0, 0);
    run_load(0, 32'h1000, 3'd6, 64'h11223344, 0, 0, 0, 0);
    run_load(0, 32'h1000, 3'd7, 64'h11223344, 0, 0, 0, 0);
    run_load(0, 32'h1002, 3'd1, 64'h8001_0000, 0, 0, 0, 0);
    run_load(0, 32'h1000, 3'd2, 64'hCAFEF00D, 0, 4, 5, 0);
    run_load(0, 32'h3000, 3'd2, 64'hDEADBEEF, 0, 1, 0, 2);
    run_load(0, 32'h2000, 3'd4, 64'h000000FF, 0, 0, 0, 0);
    run_load(0, 32'h2004, 3'd2, 64'h12345678, 1, 0, 0, 0);
    run_load(0, 32'h2008, 3'd0, 64'h7F, 0, 2, 0, 1);
    run_load(0, 32'h2009, 3'd4, 64'hAB00, 0, 0, 2, 3);
    run_load(0, 32'h200A, 3'd0, 64'h00810000, 0, 0, 1, 4);
    flush_in_idle();
    reset_mid_load();
    run_load(0, 32'h2001, 3'd0, 64'h0000F000, 0, 0, 0, 0);
    random_loads(0, 150);

    sel64 = 1'b1;
    run_load(1, 32'h0010, 3'd3, 64'h0123456789ABCDEF, 1, 0, 0, 0);
    run_load(1, 32'h0004, 3'd6, 64'h80000000_00000000, 0, 0, 0, 0);
    run_load(1, 32'h0004, 3'd2, 64'h80000000_00000000, 0, 0, 0, 0);
    run_load(1, 32'h0008, 3'd3, 64'hFEDCBA98_76543210, 0, 2, 2, 0);
    run_load(1, 32'h000C, 3'd3, 64'h1, 0, 0, 0, 0);
    run_load(1, 32'h0006, 3'd2, 64'h1, 0, 0, 0, 0);
    run_load(1, 32'h0007, 3'd0, 64'h80FF_FFFF_FFFF_FFFF, 0, 0, 0, 0);
    run_load(1, 32'h0006, 3'd5, 64'h8765_0000_0000_0000, 0, 0, 0, 0);
    run_load(1, 32'h0000, 3'd7, 64'h1, 0, 0, 0, 0);
    flush_in_idle();
    random_loads(1, 150);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Parametrised, sequential load path between the execute stage and the data memory port.
- Accepts one load request (address plus load type) and checks it for legality and alignment.
- Issues an XLEN-aligned memory read, extracts the addressed byte lane(s), then sign- or zero-extends the result.
- Returns the result to writeback over a valid/ready handshake. Supports XLEN 32/64, fault reporting, flush and response back-pressure.

Parameters:
XLEN, 32, data width; legal values 32 or 64
ADDR_W, 32, address width

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
flush  input  1  kill in-flight load (pipeline redirect)
req_valid  input  1  load request valid
req_ready  output  1  unit can accept a request
req_addr  input  ADDR_W  byte address
req_type  input  3  0 LB, 1 LH, 2 LW, 3 LD, 4 LBU, 5 LHU, 6 LWU, 7 illegal
mem_req_valid  output  1  memory read request
mem_req_ready  input  1  memory accepts request
mem_addr  output  ADDR_W  req_addr with low log2(XLEN/8) bits cleared
mem_rvalid  input  1  read data valid
mem_rdata  input  XLEN  aligned read data, little-endian lanes
mem_rerr  input  1  access error with the response
rsp_valid  output  1  result valid
rsp_ready  input  1  writeback accepts result
rsp_data  output  XLEN  extended load result
rsp_fault  output  1  load faulted
rsp_cause  output  2  0 none, 1 misaligned, 2 access fault, 3 illegal type

Behaviour:
- Reset: rst_n low at a clk edge puts the unit in IDLE and clears the killed flag. All outputs are 0, except req_ready, which is 1 after reset.
- Reset mid-operation abandons the load. The memory is reset concurrently and produces no stale response.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready = !flush.
  - On req_valid && req_ready, capture addr and type.
  - Illegal type: type 7, or type 3/6 with XLEN=32. Go to RESP with cause 3.
  - Misaligned: half needs addr[0]=0; word needs addr[1:0]=0; double needs addr[2:0]=0. Go to RESP with cause 1.
  - A request that is illegal or misaligned never asserts mem_req_valid.
  - Otherwise go to REQ.
- REQ:
  - mem_req_valid=1; mem_addr is held stable until mem_req_ready.
  - On the handshake, go to WAIT. mem_rvalid arrives no earlier than the following cycle.
- WAIT:
  - On mem_rvalid, lane = mem_rdata >> (8*addr offset), then extend per type.
  - Register rsp_data. If mem_rerr: rsp_fault=1, cause 2, rsp_data=0.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_data, rsp_fault and rsp_cause are held stable until rsp_ready.
  - On rsp_ready, go to IDLE and deassert rsp_valid.
  - The next request is accepted no earlier than the cycle after.
- Faulted responses: rsp_data=0.
- Latency, request accept to rsp_valid: 3 cycles minimum for a legal load (mem_req_ready and mem_rvalid with no wait); 1 cycle for a rejected request.
- Flush:
  - In IDLE: the request is not accepted.
  - In REQ or WAIT: sets killed. The request is still completed to keep the memory handshake legal. When the response is received, go to IDLE without asserting rsp_valid and clear killed.
  - In RESP: drop the response and go to IDLE.
  - Flush and rsp_ready in the same cycle: flush wins and the response is discarded.
- Extension: signed types replicate the top bit of the lane up to XLEN. Unsigned types zero-fill. LW at XLEN=32 passes data through unchanged.
- One outstanding load only; no buffering beyond the result register.

Decomposition:
- Shared package load_pkg holds:
  - load type encodings (LB…LWU)
  - cause codes
  - state enum
  - helper constant OFF_W = log2(XLEN/8)
- Sub-module load_extend: combinational, parametrised by XLEN. Inputs: data, offset, type. Output: extended result. Instantiated once; it is also reusable elsewhere.

Test Plan:
1. LB at 0x1003, mem_rdata=0x80123456 -> mem_addr=0x1000; rsp_data=0xFFFFFF80; cause 0; rsp_valid 3 cycles after accept.
2. LHU at 0x1002, mem_rdata=0xBEEF1234 -> rsp_data=0x0000BEEF. LH at 0x1000 with the same data -> 0x00001234.
3. LW at 0x1001 -> mem_req_valid never asserts; next cycle rsp_valid=1, fault=1, cause 1, rsp_data=0. Type 3 at XLEN=32 -> cause 3.
4. Legal LW with mem_req_ready low 4 cycles and rsp_ready low 5 cycles -> mem_addr stable while waiting; rsp_data stable; req_ready=0 until the cycle after rsp_ready.
5. Flush while in WAIT; response 0xDEADBEEF arrives -> no rsp_valid; the following LBU at 0x2000 with rdata 0x000000FF returns 0x000000FF.
6. mem_rerr=1 on response -> fault=1, cause 2, rsp_data=0. At XLEN=64: LWU at 0x4, rdata 0x80000000_00000000 -> 0x0000000080000000; LW at the same address -> 0xFFFFFFFF80000000.
